// File: rtl/uart_swc_rx_if.sv
// Read-data bus between the UART receiver and the register block.
// The register block pops with rdr_ren; status flags ride alongside.
interface uart_swc_rx_if;
  logic        rdr_ren;
  logic [15:0] rdr_rdata;
  logic        rx_empty;
  logic        rx_full;
  logic        rx_overrun;
  logic        rx_timeout;

  modport master (
    output rdr_ren,
    input  rdr_rdata, rx_empty, rx_full,
    input  rx_overrun, rx_timeout
  );

  modport slave (
    input  rdr_ren,
    output rdr_rdata, rx_empty, rx_full,
    output rx_overrun, rx_timeout
  );
endinterface

// File: rtl/uart_swc_rx.sv
// UART receive engine with receive FIFO feeding the RDR/SR fields.
// Optional idle timeout flag: define UART_SWC_RX_TIMEOUT_EN.
module uart_swc_rx #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic             pclk,
  input  logic             prst,
  input  logic             rxd,
  input  logic             cfg_en,
  input  logic [DIV_W-1:0] cfg_baud_div,
  input  logic             cfg_parity_en,
  input  logic             cfg_parity_odd,
  input  logic             cfg_clr,
  uart_swc_rx_if.slave     rdr
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  logic rxd_m, rxd_s, rxd_d, fall;

  always_ff @(posedge pclk) begin
    if (prst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_d <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      rxd_d <= rxd_s;
    end
  end

  assign fall = rxd_d & ~rxd_s;

  logic [DIV_W-1:0] div, half_m1, full_m1;

  assign div = (cfg_baud_div < DIV_W'(4)) ? DIV_W'(4) : cfg_baud_div;
  assign half_m1 = (div >> 1) - DIV_W'(1);
  assign full_m1 = div - DIV_W'(1);

  state_t           state, state_n;
  logic [DIV_W-1:0] cnt, cnt_n;
  logic [2:0]       bitn, bit_n;
  logic [7:0]       shreg, sh_n;
  logic             perr, perr_n;
  logic             push;
  logic [9:0]       push_entry;

  always_ff @(posedge pclk) begin
    if (prst) begin
      state <= IDLE;
      cnt   <= '0;
      bitn  <= '0;
      shreg <= '0;
      perr  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bitn  <= bit_n;
      shreg <= sh_n;
      perr  <= perr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bitn;
    sh_n    = shreg;
    perr_n  = perr;
    push    = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == half_m1) begin
          cnt_n   = '0;
          bit_n   = '0;
          perr_n  = 1'b0;
          state_n = rxd_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + DIV_W'(1);
        end
      end
      DATA: begin
        if (cnt == full_m1) begin
          cnt_n = '0;
          sh_n  = {rxd_s, shreg[7:1]};
          bit_n = bitn + 3'd1;
          if (bitn == 3'd7)
            state_n = cfg_parity_en ? PARITY : STOP;
        end else begin
          cnt_n = cnt + DIV_W'(1);
        end
      end
      PARITY: begin
        if (cnt == full_m1) begin
          cnt_n   = '0;
          perr_n  = ((^shreg) ^ rxd_s) != cfg_parity_odd;
          state_n = STOP;
        end else begin
          cnt_n = cnt + DIV_W'(1);
        end
      end
      STOP: begin
        if (cnt == full_m1) begin
          cnt_n   = '0;
          push    = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + DIV_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    // Dropping the enable kills any partial frame.
    if (!cfg_en) begin
      state_n = IDLE;
      cnt_n   = '0;
      push    = 1'b0;
    end
  end

  assign push_entry = {perr, ~rxd_s, shreg};

  logic [9:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr, wptr_n, rptr_n, occ;
  logic        empty_c, full_c, do_pop, do_push;
  logic [9:0]  head;

  assign occ     = wptr - rptr;
  assign empty_c = (occ == '0);
  assign full_c  = (occ == (AW+1)'(FIFO_DEPTH));
  assign head    = mem[rptr[AW-1:0]];

  always_comb begin
    do_pop  = rdr.rdr_ren & ~empty_c;
    do_push = push & (~full_c | do_pop) & ~cfg_clr;
    wptr_n  = wptr + {{AW{1'b0}}, do_push};
    rptr_n  = rptr + {{AW{1'b0}}, do_pop};
    if (cfg_clr) begin
      wptr_n = '0;
      rptr_n = '0;
    end
  end

  always_ff @(posedge pclk) begin
    if (do_push)
      mem[wptr[AW-1:0]] <= push_entry;
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      wptr           <= '0;
      rptr           <= '0;
      rdr.rx_empty   <= 1'b1;
      rdr.rx_full    <= 1'b0;
      rdr.rx_overrun <= 1'b0;
      rdr.rdr_rdata  <= '0;
    end else begin
      wptr         <= wptr_n;
      rptr         <= rptr_n;
      rdr.rx_empty <= (wptr_n == rptr_n);
      rdr.rx_full  <= ((wptr_n - rptr_n) == (AW+1)'(FIFO_DEPTH));
      if (cfg_clr) begin
        rdr.rx_overrun <= 1'b0;
        rdr.rdr_rdata  <= '0;
      end else begin
        if (push && full_c && !do_pop)
          rdr.rx_overrun <= 1'b1;
        if (rdr.rdr_ren)
          rdr.rdr_rdata <= empty_c ? 16'h0000 :
            {5'b0, head[9], head[8], 1'b1, head[7:0]};
      end
    end
  end

`ifdef UART_SWC_RX_TIMEOUT_EN
  logic [DIV_W+4:0] tcnt, tlim;
  logic             tout;

  assign tlim = {div, 5'b0} - (DIV_W+5)'(1);

  always_ff @(posedge pclk) begin
    if (prst) begin
      tcnt <= '0;
      tout <= 1'b0;
    end else if (cfg_clr || push || rdr.rdr_ren) begin
      tcnt <= '0;
      tout <= 1'b0;
    end else if (state != IDLE || rdr.rx_empty) begin
      tcnt <= '0;
    end else if (tcnt == tlim) begin
      tout <= 1'b1;
    end else begin
      tcnt <= tcnt + (DIV_W+5)'(1);
    end
  end

  assign rdr.rx_timeout = tout;
`else
  assign rdr.rx_timeout = 1'b0;
`endif

endmodule

// File: doc/uart_swc_rx.md
Name: uart_swc_rx

Overview:
- UART receive engine with a receive FIFO. It sits directly upstream of the UART/SPI APB register block and is the source of that block's RDR read data.
- Deserialises the asynchronous `rxd` line (8 data bits, LSB first, optional parity, 1 stop bit) at a programmable bit period.
- Queues each received byte with its error flags and pops one entry on each `rdr_ren` pulse from the register block.
- Status outputs feed the register block's SR field.

Parameters:
- FIFO_DEPTH, 8, number of receive entries; must be a power of 2, minimum 2.
- DIV_W, 16, width of the bit-period divisor.

Ports:
- pclk  in  1  clock; all logic is on the rising edge.
- prst  in  1  reset, synchronous, active-high.
- rxd  in  1  asynchronous serial input; idle level is high.
- cfg_en  in  1  receiver enable (from CR).
- cfg_baud_div  in  DIV_W  bit period in pclk cycles; values below 4 are treated as 4.
- cfg_parity_en  in  1  a parity bit follows the data bits.
- cfg_parity_odd  in  1  1 = odd parity, 0 = even parity.
- cfg_clr  in  1  one-cycle pulse; flushes the FIFO and clears rx_overrun.
- rdr_ren  in  1  one-cycle pop request from the register block.
- rdr_rdata  out  16  {5'b0, parity_err, frame_err, valid, data[7:0]}.
- rx_empty  out  1  FIFO empty.
- rx_full  out  1  FIFO full.
- rx_overrun  out  1  sticky; a byte was dropped because the FIFO was full.
- rx_timeout  out  1  idle-timeout flag (optional feature).

Behaviour:
- Reset values: rdr_rdata = 0, rx_empty = 1, rx_full = 0, rx_overrun = 0, rx_timeout = 0. FIFO pointers = 0, FSM in IDLE.
- Input conditioning: rxd passes through a 2-flop synchroniser (rxd_s); the synchroniser resets to 1.
- Falling-edge detect on rxd_s in IDLE starts a frame. Adds 3 cycles of input latency.
- Bit counter: counts from 0 to D-1, where D = max(cfg_baud_div, 4). Samples are taken at the bit midpoints.
- FSM states:
  - IDLE -> START on a falling edge of rxd_s while cfg_en = 1.
  - START: wait floor(D/2) cycles, then sample. If rxd_s = 1, treat as a glitch and return to IDLE with no push; otherwise go to DATA.
  - DATA: sample every D cycles, 8 samples, shifting LSB first. Then go to PARITY if cfg_parity_en, else STOP.
  - PARITY: sample after D cycles. parity_err = (XOR of data and the parity bit) != cfg_parity_odd. Go to STOP.
  - STOP: sample after D cycles. frame_err = ~rxd_s. Push the entry in the sample cycle and return to IDLE.
- The entry is always pushed, even when error flags are set.
- Configuration is sampled live. Changing cfg_baud_div or parity mid-frame is unsupported.
- cfg_en deasserted in any state: return to IDLE next cycle, abort any partial frame (no push), and retain FIFO contents.
- FIFO entry is 10 bits: {parity_err, frame_err, data}.
- Push when full: the entry is dropped and rx_overrun is set the next cycle. The existing contents are untouched.
- Simultaneous push and pop when full: both succeed, no overrun, occupancy unchanged.
- Simultaneous push and pop when empty: the pop returns valid = 0 and the push lands; afterwards rx_empty = 0.
- Pop (rdr_ren = 1):
  - rdr_rdata is registered and updates the cycle after the pulse.
  - Non-empty FIFO: returns {flags, valid = 1, data} from the head entry.
  - Empty FIFO: returns 16'h0000 with valid = 0.
  - rdr_rdata holds its value until the next rdr_ren or cfg_clr.
- rx_empty and rx_full are registered and reflect occupancy after the current cycle's push/pop.
- Pointers wrap modulo FIFO_DEPTH; occupancy is tracked with an extra pointer bit.
- cfg_clr: pointers reset to 0, rx_overrun = 0, rdr_rdata = 0.
  - A push in the same cycle is discarded.
  - cfg_clr has priority over rdr_ren.
  - cfg_clr does not affect an in-progress frame; that frame pushes normally when it completes.
- prst mid-frame: every state element returns to its reset value on the next edge.

Optional Feature:
- Macro: UART_SWC_RX_TIMEOUT_EN.
- With the macro defined:
  - A counter runs while the FIFO is non-empty and the FSM is in IDLE.
  - The counter resets on any push, any pop, cfg_clr, or when leaving IDLE.
  - rx_timeout goes to 1 when the count reaches 32*D cycles and stays 1 until the next push, pop or cfg_clr.
- Without the macro: no counter logic, and rx_timeout is tied to 0.

Test Plan:
- D = 16, no parity, send 0xA5 with a valid stop bit, then pulse rdr_ren -> the cycle after the pulse rdr_rdata = 16'h01A5; rx_empty returns to 1.
- D = 16, even parity, send 0x03 with parity bit 1 -> rdr_rdata = 16'h0503 (parity_err). Then send 0x55 with stop bit 0 -> rdr_rdata = 16'h0355 (frame_err).
- FIFO_DEPTH = 8, send 9 bytes 0x00..0x08 with no pops -> rx_full = 1, rx_overrun = 1; the 8 pops return 0x00..0x07, and a 9th pop returns 16'h0000.
- A 3-cycle low glitch on rxd with D = 16 -> no push, rx_empty stays 1. cfg_en dropped after 4 data bits -> no push, FSM in IDLE.
- FIFO full with rdr_ren coincident with a stop-bit push -> no overrun, rx_full stays 1. cfg_clr asserted while full -> rx_empty = 1, rx_overrun = 0.
- With UART_SWC_RX_TIMEOUT_EN defined, D = 8, receive 1 byte then idle -> rx_timeout rises after 256 idle cycles and clears the cycle after rdr_ren.
